// File: rtl/tdc_readout_pkg.sv
// Shared constants and state encoding for the TDC readout scheduler.
// Word types live in bits [31:28] of every FIFO word.
package tdc_readout_pkg;
    localparam int NUM_SRC = 4;

    localparam logic [3:0] HDR   = 4'b0001;
    localparam logic [3:0] TRL   = 4'b0010;
    localparam logic [3:0] LEAD  = 4'b0100;
    localparam logic [3:0] TRAIL = 4'b0101;
    localparam logic [3:0] ERR   = 4'b0110;

    localparam logic [3:0] ABORT_TIMEOUT = 4'd1;
    localparam logic [3:0] ABORT_OVERLEN = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_CAPTURE,
        S_PUSH,
        S_ABORT
    } state_t;

    // Synthetic error word that closes an aborted event.
    function automatic logic [31:0] abort_word(input logic [1:0] src, input logic [3:0] code);
        return {ERR, 2'b00, src, 20'hE0000, code};
    endfunction
endpackage

// File: rtl/tdc_readout_scheduler_arb.sv
// Four-way round-robin search: first requester at or after ptr, wrapping.
// Purely combinational; valid is low when nobody requests.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);
    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant = ptr;
        valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                grant = ptr + 2'(k);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdc_readout_scheduler.sv
// Drains TDC FIFOs one whole event at a time in round-robin order and
// forwards words to the event builder, aborting on timeout or overlength.
module tdc_readout_scheduler
    import tdc_readout_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_SRC-1:0]    fifo_empty,
    input  logic [32*NUM_SRC-1:0] fifo_data,
    output logic [NUM_SRC-1:0]    fifo_rd_en,
    input  logic [15:0]           timeout_limit,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_src,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  timeout_err,
    output logic [15:0]           drop_count,
    output logic                  busy
);
    state_t      state;
    logic [1:0]  last_grant;
    logic [15:0] empty_cnt;
    logic [15:0] word_cnt;
    logic        is_first;
    logic        is_last;
    logic [1:0]  arb_grant;
    logic        arb_valid;
    logic [31:0] word;
    logic        hs;

    rr_arbiter4 u_arb (
        .req   (~fifo_empty),
        .ptr   (last_grant + 2'd1),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign word = fifo_data[32*out_src +: 32];
    assign hs   = out_valid & out_ready;
    assign busy = (state != S_IDLE);

    // Strobe and frame markers are decoded so they land in READ and on the
    // handshake cycle itself; reset suppresses them immediately.
    assign fifo_rd_en  = (state == S_READ && !fifo_empty[out_src] && !rst) ?
                         NUM_SRC'(1) << out_src : '0;
    assign frame_start = hs & is_first & ~rst;
    assign frame_end   = hs & is_last & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= 2'd3;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= '0;
            timeout_err <= 1'b0;
            drop_count  <= '0;
            empty_cnt   <= '0;
            word_cnt    <= '0;
            is_first    <= 1'b0;
            is_last     <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: if (enable && !(&fifo_empty)) state <= S_ARB;
                S_ARB: begin
                    if (enable && arb_valid) begin
                        out_src   <= arb_grant;
                        empty_cnt <= '0;
                        word_cnt  <= '0;
                        state     <= S_READ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (!fifo_empty[out_src]) begin
                        empty_cnt <= '0;
                        state     <= S_CAPTURE;
                    end else if (timeout_limit != 16'd0 && empty_cnt >= timeout_limit - 16'd1) begin
                        out_data    <= abort_word(out_src, ABORT_TIMEOUT);
                        out_valid   <= 1'b1;
                        is_first    <= 1'b0;
                        is_last     <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_ABORT;
                    end else if (empty_cnt != 16'hFFFF) begin
                        empty_cnt <= empty_cnt + 16'd1;
                    end
                end
                S_CAPTURE: begin
                    if (word_cnt == 16'd0 && word[31:28] != HDR) begin
                        // Orphan data before any header: discard and keep looking.
                        drop_count <= (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
                        state      <= S_READ;
                    end else if (word[31:28] != TRL && word_cnt == 16'(MAX_WORDS - 1)) begin
                        // Only the trailer may occupy the last slot of an event.
                        drop_count  <= (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
                        out_data    <= abort_word(out_src, ABORT_OVERLEN);
                        out_valid   <= 1'b1;
                        is_first    <= 1'b0;
                        is_last     <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_ABORT;
                    end else begin
                        out_data  <= word;
                        out_valid <= 1'b1;
                        is_first  <= (word_cnt == 16'd0);
                        is_last   <= (word[31:28] == TRL);
                        state     <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= word_cnt + 16'd1;
                        if (is_last) begin
                            last_grant <= out_src;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_ABORT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        last_grant <= out_src;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
